// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the block-style configuration path: the loader FSM
// state encoding and a clog2 helper that the latch blocks also use to size
// their block-select fields.
// ---------------------------------------------------------------------------
package cfg_pkg;

    // Loader sequence: wait for a start request, shift one word in, present it
    // on the shared bus, then strobe the selected latch block.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETUP  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    // Ceiling log2 with a floor of one bit, so a counter for a single item
    // still has a legal (1-bit) vector width.
    function automatic int clog2_min1(input int value);
        int width;
        int span;
        width = 0;
        span  = 1;
        while (span < value) begin
            span  = span * 2;
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/cfg_sipo.sv
// ---------------------------------------------------------------------------
// cfg_sipo
// Serial-in / parallel-out word assembler for the config loader. Bits arrive
// MSB first and are shifted in from the LSB end; a bit counter tracks the
// position inside the current word and wraps back to zero on the last bit,
// at which point word_full is raised for that single transfer.
//
// Ports
//   clk        in   1         clock, all state changes on posedge
//   rst        in   1         asynchronous active-high reset
//   shift_en   in   1         accept bit_in this cycle
//   clear      in   1         restart the bit counter (word boundary)
//   bit_in     in   1         serial data
//   word_out   out  MEM_SIZE  assembled shift register contents
//   word_full  out  1         this transfer completes a word
// ---------------------------------------------------------------------------
module cfg_sipo
    import cfg_pkg::*;
#(
    parameter int MEM_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic                clear,
    input  logic                bit_in,
    output logic [MEM_SIZE-1:0] word_out,
    output logic                word_full
);

    localparam int                CNT_W    = clog2_min1(MEM_SIZE);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(MEM_SIZE - 1);

    logic [MEM_SIZE-1:0] shreg_q;
    logic [MEM_SIZE-1:0] shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]    bit_cnt_d;

    // The counter returns to zero on the final bit instead of incrementing,
    // so it never leaves 0..MEM_SIZE-1 even if the owner does not clear it.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        word_full = 1'b0;
        if (clear) begin
            bit_cnt_d = '0;
        end else if (shift_en) begin
            shreg_d = {shreg_q[MEM_SIZE-2:0], bit_in};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                word_full = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign word_out = shreg_q;

endmodule

// File: rtl/block_config_loader.sv
// ---------------------------------------------------------------------------
// block_config_loader
// Writer side of the block-style config interface. A serial bitstream taken
// over a valid/ready handshake is assembled into MEM_SIZE-bit words; each word
// is placed on the shared config_out bus and then written into the next of
// NUM_BLOCKS latch blocks with a one-cycle comb_set strobe.
//
// Ports
//   clk         in   1           clock
//   rst         in   1           asynchronous active-high reset
//   cfg_start   in   1           request a full load (looked at in IDLE only)
//   cfg_bit     in   1           serial data, MSB of each word first
//   cfg_valid   in   1           cfg_bit is valid
//   cfg_ready   out  1           loader takes cfg_bit this cycle
//   config_out  out  MEM_SIZE    word to every block's config_in
//   comb_set    out  NUM_BLOCKS  one-hot write strobe per block
//   busy        out  1           load sequence in progress
//   done        out  1           one-cycle pulse after the last block write
//
// BLK_BITS is derived from NUM_BLOCKS and must be left at its default.
// ---------------------------------------------------------------------------
module block_config_loader
    import cfg_pkg::*;
#(
    parameter int MEM_SIZE   = 16,
    parameter int NUM_BLOCKS = 4,
    parameter int BLK_BITS   = clog2_min1(NUM_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_bit,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [MEM_SIZE-1:0]   config_out,
    output logic [NUM_BLOCKS-1:0] comb_set,
    output logic                  busy,
    output logic                  done
);

    localparam logic [BLK_BITS-1:0] LAST_BLK = BLK_BITS'(NUM_BLOCKS - 1);

    cfg_state_t            state_q;
    cfg_state_t            state_d;
    logic [BLK_BITS-1:0]   blk_cnt_q;
    logic [BLK_BITS-1:0]   blk_cnt_d;
    logic [MEM_SIZE-1:0]   config_out_q;
    logic [MEM_SIZE-1:0]   config_out_d;
    logic [NUM_BLOCKS-1:0] comb_set_q;
    logic [NUM_BLOCKS-1:0] comb_set_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;

    logic                  shift_en;
    logic                  sipo_clear;
    logic [MEM_SIZE-1:0]   sipo_word;
    logic                  word_full;
    logic                  last_blk;

    // Ready comes straight from the state register, so the source sees a
    // glitch-free handshake and bits offered in SETUP/COMMIT are simply held.
    assign cfg_ready  = (state_q == SHIFT);
    assign shift_en   = cfg_ready && cfg_valid;
    assign last_blk   = (blk_cnt_q == LAST_BLK);

    // The bit counter restarts both on a fresh sequence and at every block
    // boundary, so a word always begins at bit position zero.
    assign sipo_clear = ((state_q == IDLE) && cfg_start) || (state_q == COMMIT);

    cfg_sipo #(
        .MEM_SIZE (MEM_SIZE)
    ) u_sipo (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .clear     (sipo_clear),
        .bit_in    (cfg_bit),
        .word_out  (sipo_word),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one word per SHIFT pass, then a fixed two-cycle
    // present/strobe pair before either the next word or back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start) state_d = SHIFT;
            SHIFT:   if (word_full) state_d = SETUP;
            SETUP:   state_d = COMMIT;
            COMMIT:  state_d = last_blk ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Every output is registered: config_out loads in SETUP so
    // the bus is settled a full cycle before the strobe, the strobe register
    // is high the cycle after COMMIT, and done follows one cycle behind the
    // strobe of the final block.
    always_comb begin
        blk_cnt_d    = blk_cnt_q;
        config_out_d = config_out_q;
        busy_d       = busy_q;
        comb_set_d   = '0;
        done_d       = comb_set_q[NUM_BLOCKS-1];
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    blk_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                config_out_d = sipo_word;
            end
            COMMIT: begin
                for (int k = 0; k < NUM_BLOCKS; k++) begin
                    comb_set_d[k] = (blk_cnt_q == BLK_BITS'(k));
                end
                if (last_blk) begin
                    busy_d = 1'b0;
                end else begin
                    blk_cnt_d = blk_cnt_q + BLK_BITS'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Output and counter registers; reset drops the strobe immediately so a
    // block being written when rst hits is left for the next sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q    <= '0;
            config_out_q <= '0;
            comb_set_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            blk_cnt_q    <= blk_cnt_d;
            config_out_q <= config_out_d;
            comb_set_q   <= comb_set_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign config_out = config_out_q;
    assign comb_set   = comb_set_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_block_config_loader.sv
// ---------------------------------------------------------------------------
// tb_block_config_loader
// Drives the loader with MSB-first word streams and compares the strobes it
// writes against the list of (block, word) writes a load sequence should
// produce. A second, minimal instance covers the single-block, 2-bit case.
// ---------------------------------------------------------------------------
module tb_block_config_loader;

    localparam int             MS       = 16;
    localparam int             NB       = 4;
    localparam logic [NB-1:0]  LAST_SEL = NB'(1) << (NB - 1);

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic          cfg_bit;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [MS-1:0] config_out;
    logic [NB-1:0] comb_set;
    logic          busy;
    logic          done;

    logic          s_start;
    logic          s_bit;
    logic          s_valid;
    logic          s_ready;
    logic [1:0]    s_config_out;
    logic [0:0]    s_comb_set;
    logic          s_busy;
    logic          s_done;

    typedef struct {
        logic [NB-1:0] sel;
        logic [MS-1:0] word;
        int            cycle;
    } strobe_t;

    strobe_t       obs_q[$];
    int            accept_cyc_q[$];
    bit            bits_q[$];
    logic [MS-1:0] cur_words [NB];
    int            done_cnt;
    int            cyc;
    int            vectors;
    int            miscompares;

    logic [NB-1:0] prev_cs;
    logic [MS-1:0] prev_co;
    logic          prev_done;

    block_config_loader #(
        .MEM_SIZE   (MS),
        .NUM_BLOCKS (NB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .config_out (config_out),
        .comb_set   (comb_set),
        .busy       (busy),
        .done       (done)
    );

    block_config_loader #(
        .MEM_SIZE   (2),
        .NUM_BLOCKS (1)
    ) dut_small (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (s_start),
        .cfg_bit    (s_bit),
        .cfg_valid  (s_valid),
        .cfg_ready  (s_ready),
        .config_out (s_config_out),
        .comb_set   (s_comb_set),
        .busy       (s_busy),
        .done       (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Strobe monitor on the falling edge: records every block write and
    // checks one-hot, single-cycle strobes, bus stability around each strobe
    // and that done follows the last block's strobe by one cycle.
    initial begin
        prev_cs   = '0;
        prev_co   = '0;
        prev_done = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_cs   = comb_set;
            prev_co   = config_out;
            prev_done = done;
        end else begin
            if (comb_set != '0) begin
                strobe_t ev;
                vectors++;
                if ((comb_set & (comb_set - NB'(1))) != '0) begin
                    miscompares++;
                    $display("[TB] FAIL onehot: comb_set=%b, required one-hot", comb_set);
                end
                vectors++;
                if (prev_cs != '0) begin
                    miscompares++;
                    $display("[TB] FAIL strobe_width: comb_set=%b also high previous cycle (%b), required 1 cycle", comb_set, prev_cs);
                end
                vectors++;
                if (config_out !== prev_co) begin
                    miscompares++;
                    $display("[TB] FAIL bus_before_strobe: config_out=%h, previous cycle %h, required stable", config_out, prev_co);
                end
                ev.sel   = comb_set;
                ev.word  = config_out;
                ev.cycle = cyc;
                obs_q.push_back(ev);
            end else if (prev_cs != '0) begin
                vectors++;
                if (config_out !== prev_co) begin
                    miscompares++;
                    $display("[TB] FAIL bus_after_strobe: config_out=%h, during strobe %h, required stable", config_out, prev_co);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                vectors++;
                if (prev_done || prev_cs !== LAST_SEL) begin
                    miscompares++;
                    $display("[TB] FAIL done_timing: prev comb_set=%b prev done=%b, required %b and 0", prev_cs, prev_done, LAST_SEL);
                end
            end
            prev_cs   = comb_set;
            prev_co   = config_out;
            prev_done = done;
        end
    end

    // Global time limit so a stuck DUT can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Serialise the first nwords of cur_words MSB first, then 'extra' leading
    // bits of the following word.
    task automatic build_stream(input int nwords, input int extra);
        bits_q.delete();
        for (int w = 0; w < nwords; w++)
            for (int b = MS - 1; b >= 0; b--)
                bits_q.push_back(cur_words[w][b]);
        for (int b = 0; b < extra; b++)
            bits_q.push_back(cur_words[nwords][MS-1-b]);
    endtask

    // Source model: offers each bit until the handshake takes it, with
    // random idle cycles and optional spurious start pulses. Called at
    // posedge+1; records the edge count at which each word's last bit went in.
    task automatic stream(input int gap_pct, input bit noise);
        int idx;
        int budget;
        bit acc;
        idx    = 0;
        budget = 0;
        while (idx < bits_q.size() && budget < 4000) begin
            cfg_valid = ($urandom_range(99) >= gap_pct);
            cfg_bit   = bits_q[idx];
            cfg_start = noise ? 1'($urandom_range(1)) : 1'b0;
            acc       = cfg_valid && cfg_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx % MS == 0) accept_cyc_q.push_back(cyc);
            end
            budget++;
        end
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        if (idx < bits_q.size()) begin
            miscompares++;
            $display("[TB] FAIL stream_timeout: %0d of %0d bits accepted", idx, bits_q.size());
        end
    endtask

    task automatic begin_load();
        obs_q.delete();
        accept_cyc_q.delete();
        done_cnt  = 0;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_on_start: busy=%b, required 1", busy);
        end
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [NB-1:0] exp_sel;
        rst = 1'b1; cfg_start = 0; cfg_bit = 0; cfg_valid = 0;
        s_start = 0; s_bit = 0; s_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({config_out, comb_set, cfg_ready, busy, done} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: co=%h cs=%b rdy=%b busy=%b done=%b, required all 0", config_out, comb_set, cfg_ready, busy, done);
        end
        // Reset in the middle of the second word must clear outputs at once.
        cur_words = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001};
        begin_load();
        build_stream(1, 1);
        stream(0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({config_out, comb_set, cfg_ready, busy, done} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: co=%h cs=%b rdy=%b busy=%b done=%b, required all 0", config_out, comb_set, cfg_ready, busy, done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin_load();
        build_stream(NB, 0);
        stream(0, 1'b0);
        settle();
        vectors++;
        if (obs_q.size() != NB || done_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL reload_count: strobes=%0d done=%0d, required %0d and 1", obs_q.size(), done_cnt, NB);
        end
        for (int k = 0; k < NB && k < obs_q.size(); k++) begin
            exp_sel = NB'(1) << k;
            vectors++;
            if (obs_q[k].sel !== exp_sel || obs_q[k].word !== cur_words[k]) begin
                miscompares++;
                $display("[TB] FAIL reload_write%0d: sel=%b word=%h, required %b %h", k, obs_q[k].sel, obs_q[k].word, exp_sel, cur_words[k]);
            end
        end
    endtask

    task automatic test_full_load();
        logic [NB-1:0] exp_sel;
        cur_words = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001};
        begin_load();
        build_stream(NB, 0);
        stream(0, 1'b0);
        settle();
        vectors++;
        if (obs_q.size() != NB || done_cnt != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_load_end: strobes=%0d done=%0d busy=%b, required %0d 1 0", obs_q.size(), done_cnt, busy, NB);
        end
        for (int k = 0; k < NB && k < obs_q.size() && k < accept_cyc_q.size(); k++) begin
            exp_sel = NB'(1) << k;
            vectors++;
            if (obs_q[k].sel !== exp_sel || obs_q[k].word !== cur_words[k]) begin
                miscompares++;
                $display("[TB] FAIL full_load_write%0d: sel=%b word=%h, required %b %h", k, obs_q[k].sel, obs_q[k].word, exp_sel, cur_words[k]);
            end
            vectors++;
            if (obs_q[k].cycle != accept_cyc_q[k] + 2) begin
                miscompares++;
                $display("[TB] FAIL full_load_latency%0d: strobe at edge %0d, required %0d", k, obs_q[k].cycle, accept_cyc_q[k] + 2);
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic [NB-1:0] exp_sel;
        for (int iter = 0; iter < 3; iter++) begin
            if (iter == 0) cur_words = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001};
            else for (int k = 0; k < NB; k++) cur_words[k] = MS'($urandom);
            begin_load();
            build_stream(NB, 0);
            stream((iter == 0) ? 50 : int'($urandom_range(70)), 1'b0);
            settle();
            vectors++;
            if (obs_q.size() != NB || done_cnt != 1) begin
                miscompares++;
                $display("[TB] FAIL gaps%0d_count: strobes=%0d done=%0d, required %0d and 1", iter, obs_q.size(), done_cnt, NB);
            end
            for (int k = 0; k < NB && k < obs_q.size(); k++) begin
                exp_sel = NB'(1) << k;
                vectors++;
                if (obs_q[k].sel !== exp_sel || obs_q[k].word !== cur_words[k]) begin
                    miscompares++;
                    $display("[TB] FAIL gaps%0d_write%0d: sel=%b word=%h, required %b %h", iter, k, obs_q[k].sel, obs_q[k].word, exp_sel, cur_words[k]);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [NB-1:0] exp_sel;
        for (int k = 0; k < NB; k++) cur_words[k] = MS'($urandom);
        begin_load();
        build_stream(NB, 0);
        stream(30, 1'b1);
        settle();
        vectors++;
        if (obs_q.size() != NB || done_cnt != 1 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL busy_start_end: strobes=%0d done=%0d busy=%b rdy=%b, required %0d 1 0 0", obs_q.size(), done_cnt, busy, cfg_ready, NB);
        end
        for (int k = 0; k < NB && k < obs_q.size(); k++) begin
            exp_sel = NB'(1) << k;
            vectors++;
            if (obs_q[k].sel !== exp_sel || obs_q[k].word !== cur_words[k]) begin
                miscompares++;
                $display("[TB] FAIL busy_start_write%0d: sel=%b word=%h, required %b %h", k, obs_q[k].sel, obs_q[k].word, exp_sel, cur_words[k]);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [NB-1:0] exp_sel;
        bit            saw_blk1;
        for (int k = 0; k < NB; k++) cur_words[k] = MS'($urandom);
        begin_load();
        build_stream(1, 9);
        stream(0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        saw_blk1 = 1'b0;
        foreach (obs_q[i]) if (obs_q[i].sel[1]) saw_blk1 = 1'b1;
        vectors++;
        if (obs_q.size() != 1 || saw_blk1 || done_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_word: strobes=%0d blk1_written=%0d done=%0d, required 1 0 0", obs_q.size(), saw_blk1, done_cnt);
        end
        for (int k = 0; k < NB; k++) cur_words[k] = MS'($urandom);
        begin_load();
        build_stream(NB, 0);
        stream(20, 1'b0);
        settle();
        vectors++;
        if (obs_q.size() != NB || done_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL restart_count: strobes=%0d done=%0d, required %0d and 1", obs_q.size(), done_cnt, NB);
        end
        for (int k = 0; k < NB && k < obs_q.size(); k++) begin
            exp_sel = NB'(1) << k;
            vectors++;
            if (obs_q[k].sel !== exp_sel || obs_q[k].word !== cur_words[k]) begin
                miscompares++;
                $display("[TB] FAIL restart_write%0d: sel=%b word=%h, required %b %h", k, obs_q[k].sel, obs_q[k].word, exp_sel, cur_words[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] exp_sel;
        bit            seen;
        for (int k = 0; k < NB; k++) cur_words[k] = MS'($urandom);
        begin_load();
        build_stream(NB, 0);
        stream(0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL b2b_done_wait: done=%b after 20 cycles, required 1", done);
        end
        vectors++;
        if (obs_q.size() != NB) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_count: strobes=%0d, required %0d", obs_q.size(), NB);
        end
        // Start is offered in the very cycle done is high.
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1 || done_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_restart: busy=%b rdy=%b done=%0d, required 1 1 1", busy, cfg_ready, done_cnt);
        end
        obs_q.delete();
        accept_cyc_q.delete();
        done_cnt = 0;
        for (int k = 0; k < NB; k++) cur_words[k] = MS'($urandom);
        build_stream(NB, 0);
        stream(10, 1'b0);
        settle();
        vectors++;
        if (obs_q.size() != NB || done_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_count: strobes=%0d done=%0d, required %0d and 1", obs_q.size(), done_cnt, NB);
        end
        for (int k = 0; k < NB && k < obs_q.size(); k++) begin
            exp_sel = NB'(1) << k;
            vectors++;
            if (obs_q[k].sel !== exp_sel || obs_q[k].word !== cur_words[k]) begin
                miscompares++;
                $display("[TB] FAIL b2b_write%0d: sel=%b word=%h, required %b %h", k, obs_q[k].sel, obs_q[k].word, exp_sel, cur_words[k]);
            end
        end
    endtask

    task automatic test_single_block();
        int         strobe_cycles;
        int         done_n;
        int         done_before_strobe;
        logic [1:0] co_at_strobe;
        strobe_cycles      = 0;
        done_n             = 0;
        done_before_strobe = 0;
        co_at_strobe       = '0;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        vectors++;
        if (s_ready !== 1'b1 || s_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_start: rdy=%b busy=%b, required 1 1", s_ready, s_busy);
        end
        s_valid = 1'b1;
        s_bit   = 1'b1;
        @(posedge clk);
        #1;
        s_bit = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_comb_set !== 1'b0) begin
                strobe_cycles++;
                co_at_strobe = s_config_out;
            end
            if (s_done === 1'b1) begin
                done_n++;
                if (strobe_cycles == 0) done_before_strobe++;
            end
        end
        #1;
        vectors++;
        if (strobe_cycles != 1 || co_at_strobe !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL single_strobe: cycles=%0d config_out=%b, required 1 and 10", strobe_cycles, co_at_strobe);
        end
        vectors++;
        if (done_n != 1 || done_before_strobe != 0 || s_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_done: pulses=%0d early=%0d busy=%b, required 1 0 0", done_n, done_before_strobe, s_busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        test_reset();
        test_full_load();
        test_valid_gaps();
        test_start_while_busy();
        test_reset_mid_word();
        test_back_to_back();
        test_single_block();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
